// File: rtl/threshold_compress_pkg.sv
// rtl/threshold_compress_pkg.sv - shared trit encodings and base-3 digit helper for threshold_compress
package threshold_compress_pkg;

    // 2-bit trit codes held in the staging word; 2'b10 is never produced and reads as zero
    typedef enum logic [1:0] {
        TRIT_ZERO = 2'b00,
        TRIT_POS  = 2'b01,
        TRIT_NEG  = 2'b11
    } trit_e;

    localparam int TRITS_PER_BYTE = 5;

    // Map a trit code to its base-3 digit: -1 -> 0, 0 -> 1, +1 -> 2
    function automatic logic [1:0] trit_digit(input logic [1:0] code);
        case (code)
            2'b11:   return 2'd0;
            2'b01:   return 2'd2;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/trit_byte_encoder.sv
// rtl/trit_byte_encoder.sv - packs five trit codes into one base-3 byte (0..242)
module trit_byte_encoder
    import threshold_compress_pkg::*;
(
    input  logic [2*TRITS_PER_BYTE-1:0] codes,
    output logic [7:0]                  value
);

    logic [7:0] weight;

    // Horner-free accumulation: slot i contributes digit * 3^i; the weight ends at 243, which still fits
    always_comb begin
        value  = '0;
        weight = 8'd1;
        for (int i = 0; i < TRITS_PER_BYTE; i++) begin
            value  = value + 8'(trit_digit(codes[2*i +: 2])) * weight;
            weight = weight * 8'd3;
        end
    end

endmodule

// File: rtl/threshold_compress.sv
// rtl/threshold_compress.sv - ternary threshold, trit staging and base-3 compression step (optional checks: THRESHOLD_COMPRESS_ASSERT_EN)
module threshold_compress
    import threshold_compress_pkg::*;
#(
    parameter  int OUTPUT_WIDTH  = 8,
    localparam int COMPREG_WIDTH = OUTPUT_WIDTH * 5 / 4,
    localparam int COUNTER_MAX   = COMPREG_WIDTH / 2,
    localparam int COUNTER_WIDTH = $clog2(COUNTER_MAX)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic signed [31:0]       preactivation_i,
    input  logic [31:0]              thresholds_i,
    input  logic [COUNTER_WIDTH-1:0] counter_i,
    input  logic [COMPREG_WIDTH-1:0] precompressed_i,
    input  logic [OUTPUT_WIDTH-1:0]  compressed_i,
    input  logic                     enable_i,
    output logic [COUNTER_WIDTH-1:0] counter_o,
    output logic [COMPREG_WIDTH-1:0] precompressed_o,
    output logic [OUTPUT_WIDTH-1:0]  compressed_o,
    output logic                     compreg_full_o
);

    localparam int NUM_BYTES = OUTPUT_WIDTH / 8;

    logic signed [31:0]       thr_lo;
    logic signed [31:0]       thr_hi;
    trit_e                    trit;
    logic                     slot_legal;
    logic                     last_slot;
    logic [COMPREG_WIDTH-1:0] staged;
    logic [OUTPUT_WIDTH-1:0]  encoded;

    assign thr_lo     = {{16{thresholds_i[15]}}, thresholds_i[15:0]};
    assign thr_hi     = {{16{thresholds_i[31]}}, thresholds_i[31:16]};
    assign slot_legal = counter_i < COUNTER_WIDTH'(COUNTER_MAX);
    assign last_slot  = counter_i == COUNTER_WIDTH'(COUNTER_MAX - 1);

    // Threshold decision; the high test wins even when the thresholds are inverted
    always_comb begin
        trit = TRIT_ZERO;
        if (preactivation_i > thr_hi) begin
            trit = TRIT_POS;
        end else if (preactivation_i < thr_lo) begin
            trit = TRIT_NEG;
        end
    end

    // Drop the new trit into its slot; slot 0 starts a fresh staging word
    always_comb begin
        staged = (counter_i == '0) ? '0 : precompressed_i;
        for (int s = 0; s < COUNTER_MAX; s++) begin
            if (counter_i == COUNTER_WIDTH'(s)) begin
                staged[2*s +: 2] = trit;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BYTES; g++) begin : g_byte
            trit_byte_encoder u_enc (
                .codes (staged[10*g +: 10]),
                .value (encoded[8*g +: 8])
            );
        end
    endgenerate

    // Output selection: pass-through when idle, counter reset on an illegal slot, else advance
    always_comb begin
        counter_o       = counter_i;
        precompressed_o = precompressed_i;
        compressed_o    = compressed_i;
        compreg_full_o  = 1'b0;
        if (enable_i) begin
            if (!slot_legal) begin
                counter_o = '0;
            end else begin
                counter_o       = last_slot ? '0 : counter_i + COUNTER_WIDTH'(1);
                precompressed_o = staged;
                compreg_full_o  = last_slot;
                if (last_slot) begin
                    compressed_o = encoded;
                end
            end
        end
    end

`ifdef THRESHOLD_COMPRESS_ASSERT_EN
    logic active_codes_ok;

    // Slots below the current index were written earlier and must hold legal codes
    always_comb begin
        active_codes_ok = 1'b1;
        for (int s = 0; s < COUNTER_MAX; s++) begin
            if (COUNTER_WIDTH'(s) < counter_i && precompressed_i[2*s +: 2] == 2'b10) begin
                active_codes_ok = 1'b0;
            end
        end
    end

    a_counter_legal : assert property (@(posedge clk_i) disable iff (!rst_ni) enable_i |-> slot_legal)
        else $error("threshold_compress: counter_i out of range");
    a_thresholds_ordered : assert property (@(posedge clk_i) disable iff (!rst_ni) enable_i |-> thr_lo <= thr_hi)
        else $error("threshold_compress: low threshold above high threshold");
    a_codes_legal : assert property (@(posedge clk_i) disable iff (!rst_ni) enable_i |-> active_codes_ok)
        else $error("threshold_compress: illegal trit code in staging word");
`else
    // Clock and reset only feed the optional checks; tie them off so they count as consumed
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk_i, rst_ni};
`endif

endmodule

// File: tb/tb_threshold_compress.sv
// tb/tb_threshold_compress.sv - scoreboard bench for threshold_compress with external register model
module tb_threshold_compress;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic signed [31:0] preact;
    logic [31:0]        th;
    logic [2:0]         cnt_d;
    logic [9:0]         pre_d;
    logic [7:0]         comp_d;
    logic               en;
    logic               reg_mode;
    logic               op_valid;

    logic [2:0] cnt_q;
    logic [9:0] pre_q;
    logic [7:0] comp_q;

    logic [2:0] cnt_in;
    logic [9:0] pre_in;
    logic [7:0] comp_in;
    logic [2:0] cnt_out;
    logic [9:0] pre_out;
    logic [7:0] comp_out;
    logic       full_out;

    assign cnt_in  = reg_mode ? cnt_q  : cnt_d;
    assign pre_in  = reg_mode ? pre_q  : pre_d;
    assign comp_in = reg_mode ? comp_q : comp_d;

    threshold_compress #(.OUTPUT_WIDTH(8)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .preactivation_i (preact),
        .thresholds_i    (th),
        .counter_i       (cnt_in),
        .precompressed_i (pre_in),
        .compressed_i    (comp_in),
        .enable_i        (en),
        .counter_o       (cnt_out),
        .precompressed_o (pre_out),
        .compressed_o    (comp_out),
        .compreg_full_o  (full_out)
    );

    // External GPR model holding counter, staging word and compressed word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            comp_q <= '0;
        end else if (op_valid && reg_mode) begin
            cnt_q  <= cnt_out;
            pre_q  <= pre_out;
            comp_q <= comp_out;
        end
    end

    typedef struct {
        logic [2:0] cnt;
        logic [9:0] pre;
        logic [7:0] comp;
        logic       full;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input string field, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s.%s got %0h expected %0h", tag, field, act, want);
        end
    endtask

    // Monitor: compare every presented operation against the oldest expectation
    always @(negedge clk) begin
        if (op_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow got empty expected entry");
            end else begin
                got_e = sb.pop_front();
                check(got_e.tag, "counter", 32'(cnt_out), 32'(got_e.cnt));
                check(got_e.tag, "precompressed", 32'(pre_out), 32'(got_e.pre));
                check(got_e.tag, "compressed", 32'(comp_out), 32'(got_e.comp));
                check(got_e.tag, "full", 32'(full_out), 32'(got_e.full));
            end
        end
    end

    task automatic drive(input logic e, input logic [2:0] c, input logic [9:0] pr, input logic [7:0] co,
                         input logic signed [31:0] p, input logic [2:0] xc, input logic [9:0] xp,
                         input logic [7:0] xo, input logic xf, input string tag);
        exp_t x;
        @(posedge clk);
        #1;
        en     = e;
        cnt_d  = c;
        pre_d  = pr;
        comp_d = co;
        preact = p;
        x.cnt  = xc;
        x.pre  = xp;
        x.comp = xo;
        x.full = xf;
        x.tag  = tag;
        sb.push_back(x);
        op_valid = 1'b1;
    endtask

    task automatic rop(input logic signed [31:0] p, input logic [2:0] xc, input logic [9:0] xp,
                       input logic [7:0] xo, input logic xf, input string tag);
        drive(1'b1, 3'd0, 10'h0, 8'h0, p, xc, xp, xo, xf, tag);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    localparam logic [31:0] TH_STD = 32'h0064_FF9C;
    localparam logic [31:0] TH_INV = 32'hFFCE_0032;

    initial begin
        en = 1'b0; cnt_d = '0; pre_d = '0; comp_d = '0; preact = '0;
        reg_mode = 1'b0; op_valid = 1'b0; th = TH_STD;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        drive(1'b1, 3'd0, 10'h000, 8'hA5, 32'sd200,  3'd1, 10'h001, 8'hA5, 1'b0, "thr_pos");
        drive(1'b1, 3'd0, 10'h000, 8'hA5, -32'sd200, 3'd1, 10'h003, 8'hA5, 1'b0, "thr_neg");
        drive(1'b1, 3'd0, 10'h000, 8'hA5, 32'sd0,    3'd1, 10'h000, 8'hA5, 1'b0, "thr_zero");
        drive(1'b1, 3'd0, 10'h000, 8'hA5, 32'sd100,  3'd1, 10'h000, 8'hA5, 1'b0, "thr_eq_hi");
        drive(1'b1, 3'd0, 10'h000, 8'hA5, -32'sd100, 3'd1, 10'h000, 8'hA5, 1'b0, "thr_eq_lo");
        drive(1'b1, 3'd0, 10'h3FF, 8'h11, 32'sd0,    3'd1, 10'h000, 8'h11, 1'b0, "new_word_clear");
        drive(1'b1, 3'd2, 10'h3FF, 8'h11, 32'sd200,  3'd3, 10'h3DF, 8'h11, 1'b0, "mid_passthru");
        drive(1'b0, 3'd3, 10'h2AB, 8'h5A, 32'sd200,  3'd3, 10'h2AB, 8'h5A, 1'b0, "disabled");
        drive(1'b1, 3'd6, 10'h155, 8'h33, 32'sd200,  3'd0, 10'h155, 8'h33, 1'b0, "illegal_cnt6");
        drive(1'b1, 3'd7, 10'h0F0, 8'h44, -32'sd200, 3'd0, 10'h0F0, 8'h44, 1'b0, "illegal_cnt7");
        idle();
        th = TH_INV;
        drive(1'b1, 3'd0, 10'h000, 8'h00, 32'sd0,    3'd1, 10'h001, 8'h00, 1'b0, "inverted_thr");
        idle();
        th = TH_STD;

        reg_mode = 1'b1;
        rop(32'sd200,  3'd1, 10'h001, 8'h00, 1'b0, "seq_a0");
        rop(-32'sd200, 3'd2, 10'h00D, 8'h00, 1'b0, "seq_a1");
        rop(32'sd0,    3'd3, 10'h00D, 8'h00, 1'b0, "seq_a2");
        rop(32'sd0,    3'd4, 10'h00D, 8'h00, 1'b0, "seq_a3");
        rop(32'sd0,    3'd0, 10'h00D, 8'h77, 1'b1, "seq_a4");
        for (int i = 0; i < 5; i++)
            rop(32'sd0, (i == 4) ? 3'd0 : 3'(i + 1), 10'h000, (i == 4) ? 8'h79 : 8'h77, i == 4, "seq_zero");
        rop(32'sd300, 3'd1, 10'h001, 8'h79, 1'b0, "seq_pos0");
        rop(32'sd300, 3'd2, 10'h005, 8'h79, 1'b0, "seq_pos1");
        rop(32'sd300, 3'd3, 10'h015, 8'h79, 1'b0, "seq_pos2");
        rop(32'sd300, 3'd4, 10'h055, 8'h79, 1'b0, "seq_pos3");
        rop(32'sd300, 3'd0, 10'h155, 8'hF2, 1'b1, "seq_pos4");
        rop(-32'sd300, 3'd1, 10'h003, 8'hF2, 1'b0, "seq_neg0");
        rop(-32'sd300, 3'd2, 10'h00F, 8'hF2, 1'b0, "seq_neg1");
        rop(-32'sd300, 3'd3, 10'h03F, 8'hF2, 1'b0, "seq_neg2");
        rop(-32'sd300, 3'd4, 10'h0FF, 8'hF2, 1'b0, "seq_neg3");
        rop(-32'sd300, 3'd0, 10'h3FF, 8'h00, 1'b1, "seq_neg4");
        rop(32'sd200, 3'd1, 10'h001, 8'h00, 1'b0, "pre_rst0");
        rop(32'sd200, 3'd2, 10'h005, 8'h00, 1'b0, "pre_rst1");
        idle();

        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        rop(-32'sd200, 3'd1, 10'h003, 8'h00, 1'b0, "post_rst0");
        rop(32'sd0,    3'd2, 10'h003, 8'h00, 1'b0, "post_rst1");
        rop(32'sd200,  3'd3, 10'h013, 8'h00, 1'b0, "post_rst2");
        rop(32'sd0,    3'd4, 10'h013, 8'h00, 1'b0, "post_rst3");
        rop(-32'sd200, 3'd0, 10'h313, 8'h30, 1'b1, "post_rst4");
        idle();

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
